board_loader: RTL and testbench

Upstream feeder for the piece move-generator accelerators (pawn and siblings). The CPU programs a board base address over the Avalon-MM slave and writes a start command. The block then burst-reads the 64-square board image (16 words) from SDRAM over its Avalon-MM master. It presents the assembled board as a flat vector with a valid/ack handshake to the move-generator stage.

---
 rtl/chess_pkg.sv | 24 ++
 rtl/avalon_read_burst.sv | 64 ++++++
 rtl/board_loader.sv | 136 +++++++++++++
 tb/tb_board_loader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared constants, types and register map for the chess move-generator feeder path.
package chess_pkg;

    localparam int unsigned NUM_SQUARES = 64;
    localparam int unsigned BOARD_WORDS = 16;
    localparam int unsigned SQUARE_BITS = 8;
    localparam int unsigned WORD_BITS   = 32;
    localparam int unsigned RXCOUNT_W   = $clog2(BOARD_WORDS + 1);
    localparam int unsigned WORD_IDX_W  = $clog2(BOARD_WORDS);

    typedef logic [SQUARE_BITS-1:0] piece_t;

    localparam logic [3:0] REG_CTRL    = 4'd0;
    localparam logic [3:0] REG_BASE    = 4'd1;
    localparam logic [3:0] REG_RXCOUNT = 4'd2;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StValid
    } loader_state_e;

endpackage

// File: rtl/avalon_read_burst.sv
// Issues N sequential word reads from a base address and counts in-order returns.
module avalon_read_burst
    import chess_pkg::*;
#(
    parameter int unsigned N = BOARD_WORDS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [31:0]          i_base,
    input  logic                 i_rx_en,
    input  logic                 i_waitrequest,
    input  logic                 i_readdatavalid,
    output logic                 o_read,
    output logic [31:0]          o_address,
    output logic                 o_last_accept,
    output logic                 o_rx_fire,
    output logic [RXCOUNT_W-1:0] o_rxcount
);

    logic                 r_read;
    logic [31:0]          r_addr;
    logic [RXCOUNT_W-1:0] r_issued;
    logic [RXCOUNT_W-1:0] r_rxcount;
    logic                 w_accept;

    assign w_accept      = r_read & ~i_waitrequest;
    assign o_last_accept = w_accept & (r_issued == RXCOUNT_W'(N - 1));
    assign o_rx_fire     = i_rx_en & i_readdatavalid & (r_rxcount < RXCOUNT_W'(N));

    assign o_read    = r_read;
    assign o_address = r_addr;
    assign o_rxcount = r_rxcount;

    // Address and read only move on acceptance, so they hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read   <= 1'b0;
            r_addr   <= '0;
            r_issued <= '0;
        end else if (i_start) begin
            r_read   <= 1'b1;
            r_addr   <= i_base;
            r_issued <= '0;
        end else if (w_accept) begin
            r_issued <= r_issued + 1'b1;
            r_addr   <= r_addr + 32'd4;
            if (o_last_accept) begin
                r_read <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxcount <= '0;
        end else if (i_start) begin
            r_rxcount <= '0;
        end else if (o_rx_fire) begin
            r_rxcount <= r_rxcount + 1'b1;
        end
    end

endmodule

// File: rtl/board_loader.sv
// Loads a 64-square board image from SDRAM on CPU command and hands it to the move generator.
module board_loader
    import chess_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    output logic                           slave_waitrequest,
    input  logic [3:0]                     slave_address,
    input  logic                           slave_read,
    output logic [31:0]                    slave_readdata,
    input  logic                           slave_write,
    input  logic [31:0]                    slave_writedata,
    input  logic                           master_waitrequest,
    output logic [31:0]                    master_address,
    output logic                           master_read,
    input  logic [31:0]                    master_readdata,
    input  logic                           master_readdatavalid,
    output logic                           master_write,
    output logic [31:0]                    master_writedata,
    output logic [BOARD_WORDS*WORD_BITS-1:0] board,
    output logic                           board_valid,
    input  logic                           board_ack
);

    loader_state_e                          r_state;
    loader_state_e                          w_state_d;
    logic [31:0]                            r_base;
    logic [BOARD_WORDS-1:0][WORD_BITS-1:0] r_board;

    logic                 w_start_req;
    logic                 w_start;
    logic                 w_busy;
    logic                 w_rx_en;
    logic                 w_last_accept;
    logic                 w_rx_fire;
    logic [RXCOUNT_W-1:0] w_rxcount;
    logic [RXCOUNT_W-1:0] w_rxcount_next;

    assign slave_waitrequest = 1'b0;
    assign master_write      = 1'b0;
    assign master_writedata  = '0;

    assign w_start_req = slave_write && (slave_address == REG_CTRL);
    assign w_busy      = (r_state == StIssue) || (r_state == StDrain);
    assign w_rx_en     = w_busy;
    // Starts arriving mid-load are dropped; only idle or a finished board can restart.
    assign w_start     = w_start_req && !w_busy;
    assign w_rxcount_next = w_rxcount + RXCOUNT_W'(w_rx_fire);

    avalon_read_burst #(
        .N (BOARD_WORDS)
    ) u_burst (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (w_start),
        .i_base          (r_base),
        .i_rx_en         (w_rx_en),
        .i_waitrequest   (master_waitrequest),
        .i_readdatavalid (master_readdatavalid),
        .o_read          (master_read),
        .o_address       (master_address),
        .o_last_accept   (w_last_accept),
        .o_rx_fire       (w_rx_fire),
        .o_rxcount       (w_rxcount)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_d = StIssue;
                end
            end
            StIssue: begin
                if (w_last_accept) begin
                    w_state_d = (w_rxcount_next == RXCOUNT_W'(BOARD_WORDS)) ? StValid : StDrain;
                end
            end
            StDrain: begin
                if (w_rxcount_next == RXCOUNT_W'(BOARD_WORDS)) begin
                    w_state_d = StValid;
                end
            end
            StValid: begin
                // A fresh start beats a simultaneous acknowledge.
                if (w_start) begin
                    w_state_d = StIssue;
                end else if (board_ack) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base <= '0;
        end else if (slave_write && (slave_address == REG_BASE)) begin
            r_base <= slave_writedata & ~32'h3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_board <= '0;
        end else if (w_rx_fire) begin
            r_board[w_rxcount[WORD_IDX_W-1:0]] <= master_readdata;
        end
    end

    assign board       = r_board;
    assign board_valid = (r_state == StValid);

    always_comb begin
        slave_readdata = '0;
        if (slave_read) begin
            case (slave_address)
                REG_CTRL:    slave_readdata = {30'b0, w_busy, board_valid};
                REG_BASE:    slave_readdata = r_base;
                REG_RXCOUNT: slave_readdata = {{(32 - RXCOUNT_W){1'b0}}, w_rxcount};
                default:     slave_readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_board_loader.sv
// Directed bench for board_loader with an SDRAM responder and an address scoreboard.
module tb_board_loader;
    import chess_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         slave_waitrequest;
    logic [3:0]   slave_address = '0;
    logic         slave_read = 1'b0;
    logic [31:0]  slave_readdata;
    logic         slave_write = 1'b0;
    logic [31:0]  slave_writedata = '0;
    logic         master_waitrequest = 1'b0;
    logic [31:0]  master_address;
    logic         master_read;
    logic [31:0]  master_readdata = '0;
    logic         master_readdatavalid = 1'b0;
    logic         master_write;
    logic [31:0]  master_writedata;
    logic [511:0] board;
    logic         board_valid;
    logic         board_ack = 1'b0;

    int           pass_cnt = 0;
    int           total_cnt = 0;
    logic [31:0]  exp_addr_q[$];
    logic [31:0]  pend_data[$];
    int           pend_due[$];
    int           cyc = 0;
    int           last_due = 0;
    int           req_cnt = 0;
    int           rx_delivered = 0;
    bit           rand_stall = 1'b0;
    int unsigned  max_lat = 1;
    logic [31:0]  cur_base = '0;
    logic [31:0]  cur_salt = '0;
    bit           prev_stall = 1'b0;
    logic [31:0]  prev_addr = '0;

    always #5 clk = ~clk;

    board_loader dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .slave_waitrequest    (slave_waitrequest),
        .slave_address        (slave_address),
        .slave_read           (slave_read),
        .slave_readdata       (slave_readdata),
        .slave_write          (slave_write),
        .slave_writedata      (slave_writedata),
        .master_waitrequest   (master_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_write         (master_write),
        .master_writedata     (master_writedata),
        .board                (board),
        .board_valid          (board_valid),
        .board_ack            (board_ack)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] exp_board(input logic [31:0] salt);
        logic [511:0] b;
        b = '0;
        for (int i = 0; i < 64; i++) begin
            b[8*i +: 8] = 8'(i + 1) ^ salt[8*(i % 4) +: 8];
        end
        return b;
    endfunction

    // SDRAM responder: accepts requests, returns words in order after 1..max_lat cycles.
    initial begin : mem_model
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_read", 512'(master_read), 512'(1'b1));
                    check("stall_addr", 512'(master_address), 512'(prev_addr));
                end
                prev_stall = master_read && master_waitrequest;
                prev_addr  = master_address;
                if (master_read && !master_waitrequest) begin
                    int k;
                    int due;
                    logic [31:0] word;
                    req_cnt++;
                    check("req_expected", 512'(exp_addr_q.size() != 0), 512'(1'b1));
                    if (exp_addr_q.size() != 0) begin
                        check("req_addr", 512'(master_address), 512'(exp_addr_q.pop_front()));
                    end
                    k    = int'((master_address - cur_base) >> 2);
                    word = (32'h04030201 + 32'(k) * 32'h04040404) ^ cur_salt;
                    due  = cyc + int'($urandom_range(1, max_lat));
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    pend_data.push_back(word);
                    pend_due.push_back(due);
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            master_waitrequest = rand_stall ? ($urandom_range(0, 1) == 1) : 1'b0;
            if (pend_due.size() != 0 && pend_due[0] == cyc) begin
                master_readdatavalid = 1'b1;
                master_readdata      = pend_data.pop_front();
                void'(pend_due.pop_front());
                rx_delivered++;
            end else begin
                master_readdatavalid = 1'b0;
                master_readdata      = '0;
            end
        end
    end

    task automatic slave_wr(input logic [3:0] a, input logic [31:0] d);
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        @(posedge clk);
        #1;
        slave_write = 1'b0;
    endtask

    task automatic slave_rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
        slave_address = a;
        slave_read    = 1'b1;
        #1;
        check(tag, 512'(slave_readdata), 512'(exp));
        slave_read = 1'b0;
    endtask

    task automatic start_load(input logic [31:0] base, input logic [31:0] salt);
        cur_base = base;
        cur_salt = salt;
        req_cnt  = 0;
        for (int k = 0; k < 16; k++) exp_addr_q.push_back(base + 32'(4 * k));
        slave_wr(REG_CTRL, 32'h1);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (board_valid !== 1'b1 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("valid_timeout", 512'(board_valid), 512'(1'b1));
    endtask

    task automatic check_done(input string tag, input logic [31:0] salt);
        check({tag, "_board"}, board, exp_board(salt));
        check({tag, "_reqs"}, 512'(req_cnt), 512'(16));
        check({tag, "_q_empty"}, 512'(exp_addr_q.size()), 512'(0));
        slave_rd({tag, "_status"}, REG_CTRL, 32'h1);
        slave_rd({tag, "_rxcount"}, REG_RXCOUNT, 32'd16);
    endtask

    task automatic ack_board(input string tag);
        board_ack = 1'b1;
        @(posedge clk);
        #1;
        board_ack = 1'b0;
        check({tag, "_ack_valid"}, 512'(board_valid), 512'(1'b0));
        slave_rd({tag, "_ack_status"}, REG_CTRL, 32'h0);
    endtask

    initial begin : main
        int n;
        int r0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 512'(board_valid), 512'(1'b0));
        check("rst_read", 512'(master_read), 512'(1'b0));
        check("rst_addr", 512'(master_address), 512'(0));
        check("rst_board", board, 512'(0));
        slave_rd("rst_status", REG_CTRL, 32'h0);
        slave_rd("rst_base", REG_BASE, 32'h0);
        slave_rd("rst_rxcount", REG_RXCOUNT, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero-wait, 1-cycle latency load with exact timing.
        slave_wr(REG_BASE, 32'h0000_1000);
        slave_rd("base_rb", REG_BASE, 32'h0000_1000);
        start_load(32'h0000_1000, 32'h0);
        check("first_read", 512'(master_read), 512'(1'b1));
        check("first_addr", 512'(master_address), 512'(32'h0000_1000));
        wait_valid(n);
        check("valid_latency", 512'(n), 512'(17));
        check_done("zw", 32'h0);
        ack_board("zw");
        check("ack_board_held", board, exp_board(32'h0));

        // Random stalls and latency, with an ignored start mid-issue.
        rand_stall = 1'b1;
        max_lat    = 5;
        slave_wr(REG_BASE, 32'h0000_2000);
        start_load(32'h0000_2000, 32'hA5A5_A5A5);
        repeat (3) @(posedge clk);
        #1;
        slave_rd("busy_status", REG_CTRL, 32'h2);
        slave_wr(REG_CTRL, 32'h1);
        wait_valid(n);
        check_done("rnd", 32'hA5A5_A5A5);
        ack_board("rnd");

        // Base alignment and address wrap.
        slave_wr(REG_BASE, 32'hFFFF_FFF3);
        slave_rd("base_align", REG_BASE, 32'hFFFF_FFF0);
        start_load(32'hFFFF_FFF0, 32'h5A5A_5A5A);
        wait_valid(n);
        check_done("wrap", 32'h5A5A_5A5A);

        // Start and ack in the same VALID cycle: start wins.
        board_ack = 1'b1;
        start_load(32'hFFFF_FFF0, 32'h3C3C_3C3C);
        board_ack = 1'b0;
        check("restart_valid", 512'(board_valid), 512'(1'b0));
        check("restart_read", 512'(master_read), 512'(1'b1));
        wait_valid(n);
        check_done("restart", 32'h3C3C_3C3C);
        ack_board("restart");

        // Reset after 7 returns, then a clean reload.
        slave_wr(REG_BASE, 32'h0000_3000);
        r0 = rx_delivered;
        start_load(32'h0000_3000, 32'h0F0F_0F0F);
        n = 0;
        while ((rx_delivered - r0) < 7 && n < 500) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("rx7_timeout", 512'((rx_delivered - r0) >= 7), 512'(1'b1));
        @(posedge clk);
        #1;
        slave_rd("mid_rxcount", REG_RXCOUNT, 32'd7);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 512'(board_valid), 512'(1'b0));
        check("mid_rst_read", 512'(master_read), 512'(1'b0));
        check("mid_rst_addr", 512'(master_address), 512'(0));
        check("mid_rst_board", board, 512'(0));
        slave_rd("mid_rst_base", REG_BASE, 32'h0);
        slave_rd("mid_rst_status", REG_CTRL, 32'h0);
        exp_addr_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        slave_rd("post_rst_rxcount", REG_RXCOUNT, 32'h0);
        slave_rd("post_rst_status", REG_CTRL, 32'h0);
        check("post_rst_board", board, 512'(0));
        slave_wr(REG_BASE, 32'h0000_4000);
        start_load(32'h0000_4000, 32'h1234_5678);
        wait_valid(n);
        check_done("reload", 32'h1234_5678);
        ack_board("reload");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
